// File: rtl/ysyx22041405_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx22041405_rr_arbiter_pkg
//
// Shared definitions for the round-robin arbiter that sits in front of the
// unified memory port (IFU / LSU and friends).
//
// Contents:
//   RR_N, RR_IDW  - requester count and index width used by the memory-port
//                   instance; the modules take these as parameter defaults.
//   rr_state_e    - arbiter FSM state encoding (IDLE / GRANT / WAIT).
// ----------------------------------------------------------------------------
package ysyx22041405_rr_arbiter_pkg;

   // Default sizing for the memory-port arbiter. RR_IDW must equal log2(RR_N).
   localparam int RR_N   = 4;
   localparam int RR_IDW = 2;

   // FSM encoding. IDLE is zero so a cleared state register means "no
   // transaction in flight".
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } rr_state_e;

endpackage : ysyx22041405_rr_arbiter_pkg

// File: rtl/ysyx22041405_rr_arbiter_pick.sv
// ----------------------------------------------------------------------------
// ysyx22041405_rr_pick
//
// Combinational masked priority picker for the round-robin arbiter.
// The winner is the lowest set request at or above ptr; if there is none,
// the search wraps and the lowest set request overall wins.
//
// Ports:
//   req    in  [N-1:0]    request vector
//   ptr    in  [IDW-1:0]  rotating priority pointer
//   onehot out [N-1:0]    one-hot winner (zero when req is zero)
//   idx    out [IDW-1:0]  binary index of the winner (zero when req is zero)
//   any    out            at least one request is set
// ----------------------------------------------------------------------------
module ysyx22041405_rr_pick
   import ysyx22041405_rr_arbiter_pkg::*;
#(
   parameter int N   = RR_N,
   parameter int IDW = RR_IDW
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   onehot,
   output logic [IDW-1:0] idx,
   output logic           any
);

   logic [N-1:0] mask;
   logic [N-1:0] masked;
   logic [N-1:0] masked_lsb;
   logic [N-1:0] req_lsb;

   // Thermometer mask that keeps only bit positions at or above ptr.
   // Equivalent to ~((1 << ptr) - 1) without a variable shift.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (IDW'(i) >= ptr);
      end
   end

   // Two lowest-set-bit searches using the x & -x trick: one over the
   // masked requests, one over all requests for the wrap-around case.
   // When the masked set is empty, the unmasked search provides the winner.
   always_comb begin
      masked     = req & mask;
      masked_lsb = masked & (~masked + N'(1));
      req_lsb    = req & (~req + N'(1));
      onehot     = (|masked) ? masked_lsb : req_lsb;
      any        = |req;
   end

   // One-hot to binary encode. OR-ing in the index is safe because onehot
   // has at most one bit set.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) begin
            idx = idx | IDW'(i);
         end
      end
   end

endmodule : ysyx22041405_rr_pick

// File: rtl/ysyx22041405_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx22041405_rr_arbiter
//
// Round-robin arbiter for a single-outstanding shared resource. A grant is
// held for a whole transaction (accept through response done), then the
// priority pointer rotates past the winner. There is always one IDLE cycle
// between done and the next grant; that cycle is the re-arbitration slot.
//
// Ports:
//   clk          in               clock
//   rst          in               synchronous active-high reset
//   req_i        in  [N-1:0]      per-requester request, held until accepted
//   gnt_o        out [N-1:0]      one-hot grant, registered
//   gnt_idx_o    out [IDW-1:0]    binary index of the grantee, registered
//   gnt_valid_o  out              grant active (GRANT or WAIT)
//   res_ready_i  in               resource accepts the granted request
//   res_done_i   in               resource completes the response
//   busy_o       out              arbiter not idle
// ----------------------------------------------------------------------------
module ysyx22041405_rr_arbiter
   import ysyx22041405_rr_arbiter_pkg::*;
#(
   parameter int N   = RR_N,
   parameter int IDW = RR_IDW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] gnt_idx_o,
   output logic           gnt_valid_o,
   input  logic           res_ready_i,
   input  logic           res_done_i,
   output logic           busy_o
);

   rr_state_e      state;
   logic [IDW-1:0] ptr;

   logic [N-1:0]   pick_onehot;
   logic [IDW-1:0] pick_idx;
   logic           pick_any;
   logic           granted_req;

   // The picker is only consulted in IDLE; in GRANT and WAIT its output is
   // ignored so the grant stays frozen while requests move around.
   ysyx22041405_rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req    (req_i),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Whether the current grantee is still requesting; a drop before
   // acceptance is treated as an abort.
   always_comb begin
      granted_req = req_i[gnt_idx_o];
   end

   // Arbiter FSM with registered outputs. Every transition writes the
   // outputs for the state it enters, so gnt_o is non-zero exactly when
   // gnt_valid_o is set and busy_o tracks state != IDLE.
   //
   // ptr only moves when a transaction completes (ready+done in GRANT, or
   // done in WAIT), so an abort leaves priority where it was. The +1 wraps
   // naturally because N is a power of two and ptr is IDW bits wide.
   //
   // In GRANT, ready takes priority over a dropped request: once the
   // resource has accepted, the transaction must run to completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         gnt_o       <= '0;
         gnt_idx_o   <= '0;
         gnt_valid_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state       <= ST_GRANT;
                  gnt_o       <= pick_onehot;
                  gnt_idx_o   <= pick_idx;
                  gnt_valid_o <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end

            ST_GRANT: begin
               if (res_ready_i && res_done_i) begin
                  state       <= ST_IDLE;
                  ptr         <= gnt_idx_o + IDW'(1);
                  gnt_o       <= '0;
                  gnt_idx_o   <= '0;
                  gnt_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
               end else if (res_ready_i) begin
                  state <= ST_WAIT;
               end else if (!granted_req) begin
                  state       <= ST_IDLE;
                  gnt_o       <= '0;
                  gnt_idx_o   <= '0;
                  gnt_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
               end
            end

            ST_WAIT: begin
               if (res_done_i) begin
                  state       <= ST_IDLE;
                  ptr         <= gnt_idx_o + IDW'(1);
                  gnt_o       <= '0;
                  gnt_idx_o   <= '0;
                  gnt_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
               end
            end

            default: begin
               state       <= ST_IDLE;
               gnt_o       <= '0;
               gnt_idx_o   <= '0;
               gnt_valid_o <= 1'b0;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule : ysyx22041405_rr_arbiter

// File: tb/tb_ysyx22041405_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx22041405_rr_arbiter
//
// Cycle-by-cycle vector table for the 4-requester arbiter: each record is
// the inputs driven for one clock and the outputs expected just after that
// edge. The priority pointer is observed indirectly by offering all four
// requests and checking which index wins. A hand-written loop then checks
// full rotation fairness with every requester asserting.
// ----------------------------------------------------------------------------
module tb_ysyx22041405_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req_i;
   logic [3:0] gnt_o;
   logic [1:0] gnt_idx_o;
   logic       gnt_valid_o;
   logic       res_ready_i;
   logic       res_done_i;
   logic       busy_o;

   int checks;
   int failures;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       ready;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic       busy;
      string      name;
   } vec_t;

   vec_t vecs[$];

   ysyx22041405_rr_arbiter #(
      .N   (4),
      .IDW (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .res_ready_i (res_ready_i),
      .res_done_i  (res_done_i),
      .busy_o      (busy_o)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Append one cycle record to the vector table.
   function automatic void addVec(input logic r, input logic [3:0] q,
                                  input logic rd, input logic dn,
                                  input logic [3:0] g, input logic [1:0] ix,
                                  input logic v, input logic b,
                                  input string nm);
      vec_t t;
      t.rst = r; t.req = q; t.ready = rd; t.done = dn;
      t.gnt = g; t.idx = ix; t.valid = v; t.busy = b; t.name = nm;
      vecs.push_back(t);
   endfunction

   // Drive inputs on the falling edge, let one rising edge pass, then wait
   // a little so registered outputs are sampled away from the edge.
   task automatic applyStimulus(input logic r, input logic [3:0] q,
                                input logic rd, input logic dn);
      @(negedge clk);
      rst         = r;
      req_i       = q;
      res_ready_i = rd;
      res_done_i  = dn;
      @(posedge clk);
      #1;
   endtask

   // Compare all four outputs against one expected record.
   task automatic checkOutput(input string nm, input logic [3:0] eg,
                              input logic [1:0] ei, input logic ev,
                              input logic eb);
      checks++;
      if (gnt_o !== eg || gnt_idx_o !== ei || gnt_valid_o !== ev || busy_o !== eb) begin
         failures++;
         $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b busy=%b, want gnt=%b idx=%0d valid=%b busy=%b",
                  nm, gnt_o, gnt_idx_o, gnt_valid_o, busy_o, eg, ei, ev, eb);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      req_i       = '0;
      res_ready_i = 1'b0;
      res_done_i  = 1'b0;

      //      rst  req      rdy   done  gnt      idx   vld   busy  name
      addVec(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset");
      // Basic grant with ptr=0: lowest of 1010 is index 1.
      addVec(1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "basic_grant");
      addVec(1'b0, 4'b1010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "basic_wait");
      addVec(1'b0, 4'b1010, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "basic_done");
      // ptr is now 2: all-request offer must pick index 2.
      addVec(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "ptr_is_2");
      // Ready+done together in GRANT: straight to IDLE, ptr becomes 3.
      addVec(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rdy_done_same");
      // Wrap-around with ptr=3: masked 0011 is empty, fall back to index 0.
      addVec(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "wrap_grant");
      addVec(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "wrap_wait");
      addVec(1'b0, 4'b1100, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "wait_ignores_req");
      addVec(1'b0, 4'b1100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_done");
      // ptr is now 1.
      addVec(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "ptr_is_1");
      addVec(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "done_ptr_2");
      // Abort: grant index 2, requester drops before ready.
      addVec(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "abort_grant");
      addVec(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "abort_drop");
      addVec(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "stray_idle");
      // ptr unchanged at 2 after abort.
      addVec(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "ptr_kept_2");
      // Done without ready in GRANT is ignored.
      addVec(1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "done_no_ready");
      // Ready wins over a same-cycle drop.
      addVec(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "ready_over_drop");
      addVec(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "done_ptr_3");
      // Reset mid-WAIT, ptr=3 so 0100 wraps to index 2.
      addVec(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "rstw_grant");
      addVec(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "rstw_wait");
      addVec(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_mid_wait");
      // ptr back to 0: 0110 grants index 1.
      addVec(1'b0, 4'b0110, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "post_rst_grant");
      addVec(1'b0, 4'b0110, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "post_rst_done");
      addVec(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "ready_in_idle");

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].ready, vecs[i].done);
         checkOutput(vecs[i].name, vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].busy);
      end

      // Rotation fairness: all four requesting, grants go 0,1,2,3,0 with the
      // next grant appearing one cycle after each done.
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput("rot_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         logic [1:0] ek;
         logic [3:0] eg;
         ek = 2'(k % 4);
         eg = 4'b0001 << ek;
         applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
         checkOutput($sformatf("rot_grant_%0d", k), eg, ek, 1'b1, 1'b1);
         applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
         checkOutput($sformatf("rot_wait_%0d", k), eg, ek, 1'b1, 1'b1);
         applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
         checkOutput($sformatf("rot_done_%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ysyx22041405_rr_arbiter
